// File: rtl/spart_tx_interface_pkg.sv
// Shared constants and transmit-state encoding for the SPART hex printer path.
package spart_tx_interface_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } tx_state_t;

endpackage

// File: rtl/spart_tx_interface_hex_nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit; zero latency, no flow control.
module hex_nibble_to_ascii
    import spart_tx_interface_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'd0, nibble};
        end else begin
            ascii = ASCII_A + {4'd0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/spart_tx_interface.sv
// Prints a CPU word to the SPART as hex digits (+ optional CR LF), one byte per tbr-paced strobe.
// First strobe 1 cycle after accept; cpu_ready is low for the whole word, each byte waits on tbr.
module spart_tx_interface
    import spart_tx_interface_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit SEND_CRLF  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] cpu_data,
    input  logic                    cpu_valid,
    output logic                    cpu_ready,
    input  logic                    tbr,
    output logic [7:0]              tx_data,
    output logic                    tx_wr,
    output logic                    busy
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int CW    = $clog2(NUM_DIGITS + 2);
    localparam int TOTAL = NUM_DIGITS + (SEND_CRLF ? 2 : 0);
    localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CR_IDX   = CW'(NUM_DIGITS);

    tx_state_t         state, state_nxt;
    logic [DW-1:0]     shift_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        digit_ascii;
    logic [7:0]        cur_byte;
    logic              strobe;

    hex_nibble_to_ascii u_hex (
        .nibble (shift_q[DW-1 -: 4]),
        .ascii  (digit_ascii)
    );

    always_comb begin
        if (cnt_q < CR_IDX) begin
            cur_byte = digit_ascii;
        end else if (cnt_q == CR_IDX) begin
            cur_byte = ASCII_CR;
        end else begin
            cur_byte = ASCII_LF;
        end
    end

    assign strobe    = (state == SEND) && tbr;
    assign cpu_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign tx_wr     = strobe;
    // The strobed byte is driven straight through so the first write lands in the SEND cycle.
    assign tx_data   = strobe ? cur_byte : tx_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cpu_valid) state_nxt = SEND;
            SEND: if (tbr) state_nxt = HOLD;
            HOLD: state_nxt = WAIT;
            WAIT: if (tbr) state_nxt = (cnt_q == LAST_IDX) ? IDLE : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= 8'h00;
        end else begin
            if (state == IDLE && cpu_valid) begin
                shift_q <= cpu_data;
                cnt_q   <= '0;
            end
            if (strobe) begin
                tx_data_q <= cur_byte;
                shift_q   <= shift_q << 4;
            end
            if (state == WAIT && tbr) begin
                cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule
